// File: rtl/pc_fetch_gen.sv
// Fetch-stage PC generator: sequential +2/+4 stepping, trap/branch redirect, stall and boot/halt gating.
// Optional macro PC_MISALIGN_CHECK_EN adds the registered MisalignE flag for misaligned branch targets.
module pc_fetch_gen #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
  parameter int              BOOT_DELAY   = 4,
  parameter int              C_EXT        = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallF,
  input  logic            FetchReadyF,
  input  logic            InstrCompF,
  input  logic            RedirectE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            TrapValid,
  input  logic [XLEN-1:0] TrapVector,
  input  logic            HaltReq,
  input  logic            ResumeReq,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCNextSeqF,
  output logic            FetchValidF,
  output logic            FlushD,
  output logic            Halted
`ifdef PC_MISALIGN_CHECK_EN
  ,
  output logic            MisalignE
`endif
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Without compressed instructions targets must be word aligned, otherwise halfword aligned.
  localparam logic [XLEN-1:0] ALIGN_MASK = (C_EXT != 0) ?
                                           {{(XLEN-1){1'b1}}, 1'b0} :
                                           {{(XLEN-2){1'b1}}, 2'b00};

  state_t          state;
  state_t          state_next;
  logic [31:0]     boot_cnt;
  logic [31:0]     boot_cnt_next;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] step;
  logic            flush_next;
  logic            trap_take;
  logic            jump_take;

  assign step        = ((C_EXT != 0) && InstrCompF) ? XLEN'(2) : XLEN'(4);
  assign PCNextSeqF  = PCF + step;
  assign FetchValidF = (state == RUN) && !StallF;
  assign Halted      = (state == HALTED);

  // Redirects are honoured in RUN and HALTED; a trap always beats a branch.
  assign trap_take = (state != BOOT) && TrapValid;
  assign jump_take = (state != BOOT) && !TrapValid && RedirectE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= BOOT;
      boot_cnt <= 32'd0;
      PCF      <= RESET_VECTOR;
      FlushD   <= 1'b0;
    end else begin
      state    <= state_next;
      boot_cnt <= boot_cnt_next;
      PCF      <= pc_next;
      FlushD   <= flush_next;
    end
  end

  always_comb begin
    state_next    = state;
    boot_cnt_next = boot_cnt;
    pc_next       = PCF;
    flush_next    = 1'b0;

    // A stall drops FetchValidF, so the hold case falls out of the final else.
    if (trap_take) begin
      pc_next    = TrapVector & ALIGN_MASK;
      flush_next = 1'b1;
    end else if (jump_take) begin
      pc_next    = PCTargetE & ALIGN_MASK;
      flush_next = 1'b1;
    end else if (FetchValidF && FetchReadyF) begin
      pc_next = PCNextSeqF;
    end

    case (state)
      BOOT: begin
        boot_cnt_next = boot_cnt + 32'd1;
        if (boot_cnt == 32'(BOOT_DELAY)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (HaltReq) begin
          state_next = HALTED;
        end
      end
      HALTED: begin
        if (ResumeReq) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

`ifdef PC_MISALIGN_CHECK_EN
  logic misalign_next;

  assign misalign_next = jump_take &&
                         (PCTargetE[0] || ((C_EXT == 0) && PCTargetE[1]));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      MisalignE <= 1'b0;
    end else begin
      MisalignE <= misalign_next;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Directed self-checking bench for pc_fetch_gen (XLEN=64, BOOT_DELAY=4, C_EXT=1, reset vector 0x8000_0000).
module tb_pc_fetch_gen;

  localparam int XL = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          StallF;
  logic          FetchReadyF;
  logic          InstrCompF;
  logic          RedirectE;
  logic [XL-1:0] PCTargetE;
  logic          TrapValid;
  logic [XL-1:0] TrapVector;
  logic          HaltReq;
  logic          ResumeReq;
  logic [XL-1:0] PCF;
  logic [XL-1:0] PCNextSeqF;
  logic          FetchValidF;
  logic          FlushD;
  logic          Halted;
`ifdef PC_MISALIGN_CHECK_EN
  logic          MisalignE;
`endif

  int total = 0;
  int bad   = 0;

  pc_fetch_gen #(
    .XLEN(XL),
    .RESET_VECTOR(64'h0000_0000_8000_0000),
    .BOOT_DELAY(4),
    .C_EXT(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .StallF(StallF),
    .FetchReadyF(FetchReadyF),
    .InstrCompF(InstrCompF),
    .RedirectE(RedirectE),
    .PCTargetE(PCTargetE),
    .TrapValid(TrapValid),
    .TrapVector(TrapVector),
    .HaltReq(HaltReq),
    .ResumeReq(ResumeReq),
    .PCF(PCF),
    .PCNextSeqF(PCNextSeqF),
    .FetchValidF(FetchValidF),
    .FlushD(FlushD),
    .Halted(Halted)
`ifdef PC_MISALIGN_CHECK_EN
    ,
    .MisalignE(MisalignE)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [XL-1:0] got, input logic [XL-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic setInputs(input logic stall, input logic ready, input logic comp,
                           input logic redir, input logic [XL-1:0] target,
                           input logic trap, input logic [XL-1:0] tvec,
                           input logic halt, input logic resume);
    StallF      = stall;
    FetchReadyF = ready;
    InstrCompF  = comp;
    RedirectE   = redir;
    PCTargetE   = target;
    TrapValid   = trap;
    TrapVector  = tvec;
    HaltReq     = halt;
    ResumeReq   = resume;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic stall, input logic ready, input logic comp,
                               input logic redir, input logic [XL-1:0] target,
                               input logic trap, input logic [XL-1:0] tvec,
                               input logic halt, input logic resume);
    setInputs(stall, ready, comp, redir, target, trap, tvec, halt, resume);
    stepClock();
  endtask

  initial begin
    rst_n = 1'b0;
    setInputs(0, 1, 0, 0, 64'h0, 0, 64'h0, 0, 0);
    repeat (3) stepClock();
    checkOutput("rst_pc",     PCF,         64'h8000_0000);
    checkOutput("rst_valid",  64'(FetchValidF), 64'd0);
    checkOutput("rst_flush",  64'(FlushD),      64'd0);
    checkOutput("rst_halted", 64'(Halted),      64'd0);

    // Boot window: four cycles without a fetch request, then sequential fetch
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 0, 64'h0, 0, 64'h0, 0, 0);
      checkOutput($sformatf("boot_valid%0d", i), 64'(FetchValidF), 64'd0);
      checkOutput($sformatf("boot_pc%0d", i), PCF, 64'h8000_0000);
    end
    applyStimulus(0, 1, 0, 0, 64'h0, 0, 64'h0, 0, 0);
    checkOutput("run_valid", 64'(FetchValidF), 64'd1);
    checkOutput("run_pc0",   PCF, 64'h8000_0000);
    applyStimulus(0, 1, 0, 0, 64'h0, 0, 64'h0, 0, 0);
    checkOutput("run_pc1",   PCF, 64'h8000_0004);
    applyStimulus(0, 1, 0, 0, 64'h0, 0, 64'h0, 0, 0);
    checkOutput("run_pc2",   PCF, 64'h8000_0008);
    checkOutput("seq4",      PCNextSeqF, 64'h8000_000C);

    // Compressed stepping from 0x100
    applyStimulus(0, 0, 0, 1, 64'h100, 0, 64'h0, 0, 0);
    checkOutput("redir_pc",    PCF, 64'h100);
    checkOutput("redir_flush", 64'(FlushD), 64'd1);
    setInputs(0, 1, 1, 0, 64'h0, 0, 64'h0, 0, 0);
    #1;
    checkOutput("seq2", PCNextSeqF, 64'h102);
    stepClock();
    checkOutput("comp_pc0",    PCF, 64'h102);
    checkOutput("flush_clear", 64'(FlushD), 64'd0);
    applyStimulus(0, 1, 0, 0, 64'h0, 0, 64'h0, 0, 0);
    checkOutput("comp_pc1", PCF, 64'h106);
    applyStimulus(0, 1, 1, 0, 64'h0, 0, 64'h0, 0, 0);
    checkOutput("comp_pc2", PCF, 64'h108);

    // Stall at 0x200 for two cycles, then release; then an un-accepted request holds
    applyStimulus(0, 0, 0, 1, 64'h200, 0, 64'h0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1, 0, 0, 64'h0, 0, 64'h0, 0, 0);
      checkOutput($sformatf("stall_pc%0d", i), PCF, 64'h200);
      checkOutput($sformatf("stall_valid%0d", i), 64'(FetchValidF), 64'd0);
    end
    applyStimulus(0, 1, 0, 0, 64'h0, 0, 64'h0, 0, 0);
    checkOutput("unstall_pc", PCF, 64'h204);
    applyStimulus(0, 0, 0, 0, 64'h0, 0, 64'h0, 0, 0);
    checkOutput("noready_pc",    PCF, 64'h204);
    checkOutput("noready_valid", 64'(FetchValidF), 64'd1);

    // Trap beats branch beats stall; target low bit masked
    applyStimulus(1, 1, 0, 1, 64'h1235, 1, 64'h400, 0, 0);
    checkOutput("trap_pc",    PCF, 64'h400);
    checkOutput("trap_flush", 64'(FlushD), 64'd1);
    applyStimulus(0, 0, 0, 0, 64'h0, 0, 64'h0, 0, 0);
    checkOutput("trap_flush_once", 64'(FlushD), 64'd0);
    checkOutput("trap_valid",      64'(FetchValidF), 64'd1);
    applyStimulus(1, 1, 0, 1, 64'h1235, 0, 64'h0, 0, 0);
    checkOutput("br_pc",    PCF, 64'h1234);
    checkOutput("br_flush", 64'(FlushD), 64'd1);

    // Wrap from the top of the address space
    applyStimulus(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 0, 0);
    setInputs(0, 1, 0, 0, 64'h0, 0, 64'h0, 0, 0);
    #1;
    checkOutput("wrap_seq", PCNextSeqF, 64'h0);
    stepClock();
    checkOutput("wrap_pc",    PCF, 64'h0);
    checkOutput("wrap_valid", 64'(FetchValidF), 64'd1);

    // Halt at 0x300, then resume (resume beats a simultaneous halt)
    applyStimulus(0, 0, 0, 1, 64'h300, 0, 64'h0, 0, 0);
    applyStimulus(0, 0, 0, 0, 64'h0, 0, 64'h0, 1, 0);
    checkOutput("halt_flag",  64'(Halted), 64'd1);
    checkOutput("halt_valid", 64'(FetchValidF), 64'd0);
    checkOutput("halt_pc",    PCF, 64'h300);
    applyStimulus(0, 1, 0, 0, 64'h0, 0, 64'h0, 0, 0);
    checkOutput("halt_hold_pc", PCF, 64'h300);
    applyStimulus(0, 0, 0, 0, 64'h0, 0, 64'h0, 1, 1);
    checkOutput("resume_flag",  64'(Halted), 64'd0);
    checkOutput("resume_valid", 64'(FetchValidF), 64'd1);
    checkOutput("resume_pc",    PCF, 64'h300);
    applyStimulus(0, 1, 0, 0, 64'h0, 0, 64'h0, 0, 0);
    checkOutput("resume_next", PCF, 64'h304);

    // Redirect while halted updates PCF and flushes but stays halted
    applyStimulus(0, 0, 0, 0, 64'h0, 0, 64'h0, 1, 0);
    applyStimulus(0, 0, 0, 1, 64'h600, 0, 64'h0, 0, 0);
    checkOutput("hred_pc",     PCF, 64'h600);
    checkOutput("hred_halted", 64'(Halted), 64'd1);
    checkOutput("hred_flush",  64'(FlushD), 64'd1);

    // Halt together with a redirect in RUN: redirect applied, then halted
    applyStimulus(0, 0, 0, 0, 64'h0, 0, 64'h0, 0, 1);
    applyStimulus(0, 1, 0, 1, 64'h700, 0, 64'h0, 1, 0);
    checkOutput("rhalt_pc",     PCF, 64'h700);
    checkOutput("rhalt_halted", 64'(Halted), 64'd1);
    applyStimulus(0, 0, 0, 0, 64'h0, 0, 64'h0, 0, 1);

`ifdef PC_MISALIGN_CHECK_EN
    applyStimulus(0, 0, 0, 1, 64'h301, 0, 64'h0, 0, 0);
    checkOutput("mis_pc",    PCF, 64'h300);
    checkOutput("mis_pulse", 64'(MisalignE), 64'd1);
    applyStimulus(0, 0, 0, 0, 64'h0, 0, 64'h0, 0, 0);
    checkOutput("mis_clear", 64'(MisalignE), 64'd0);
`endif

    // Reset with a pending redirect discards it; redirects in BOOT are ignored
    rst_n = 1'b0;
    applyStimulus(0, 1, 0, 1, 64'h900, 1, 64'hA00, 0, 0);
    checkOutput("rst2_pc",    PCF, 64'h8000_0000);
    checkOutput("rst2_flush", 64'(FlushD), 64'd0);
    rst_n = 1'b1;
    applyStimulus(0, 1, 0, 1, 64'h900, 1, 64'hA00, 0, 0);
    checkOutput("boot_ign_pc",    PCF, 64'h8000_0000);
    checkOutput("boot_ign_flush", 64'(FlushD), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
